// File: rtl/fifo_loader_pkg.sv
// Shared types and sizing helpers for the transpose-FIFO row loader and its
// skew-enable decoder.
package fifo_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // Width of an unsigned counter holding 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skew_shift_gen.sv
// Diagonal window decode: FIFO k shifts while k <= t <= k+DEPTH-1, giving each
// FIFO exactly DEPTH shift cycles, staggered by one cycle per FIFO.
module skew_shift_gen
    import fifo_loader_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [cnt_width(2*DEPTH)-1:0] t,
    input  logic                          active,
    output logic [DEPTH-1:0]              shift_en
);

    localparam int TW = cnt_width(2*DEPTH);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
        localparam logic [TW-1:0] LO = TW'(gi);
        localparam logic [TW-1:0] SPAN = TW'(DEPTH);
        logic [TW-1:0] offset;

        // Modular difference: when t < LO it wraps to at least DEPTH+1,
        // so one unsigned compare covers both window edges.
        assign offset = t - LO;
        assign shift_en[gi] = active && (offset < SPAN);
    end

endmodule

// File: rtl/fifo_row_loader.sv
// Assembles a row-major element stream into DEPTH-wide rows, writes each row
// into its transpose FIFO, then drives the skewed drain enables.
module fifo_row_loader
    import fifo_loader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic signed [BITS-1:0] in_data,
    output logic                   in_ready,
    output logic signed [BITS-1:0] row_out [0:DEPTH-1],
    output logic [DEPTH-1:0]       wr_en,
    output logic [DEPTH-1:0]       shift_en,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = cnt_width(DEPTH);
    localparam int TW = cnt_width(2*DEPTH);
    localparam logic [CW-1:0] LAST  = CW'(DEPTH-1);
    localparam logic [TW-1:0] T_END = TW'(2*DEPTH-2);

    loader_state_t           state_reg, state_next;
    logic [CW-1:0]           col_reg, col_next;
    logic [CW-1:0]           row_reg, row_next;
    logic [TW-1:0]           t_reg, t_next;
    logic [DEPTH-1:0]        wr_en_reg, wr_en_next;
    logic signed [BITS-1:0]  row_buf [0:DEPTH-1];
    logic                    accept;

    assign accept = in_valid && (state_reg == FILL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            t_reg     <= '0;
            wr_en_reg <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            t_reg     <= t_next;
            wr_en_reg <= wr_en_next;
        end
    end

    // The FIFO captures row_buf at the same edge a new beat may overwrite
    // row_buf[0], so it always sees the completed row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                row_buf[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (col_reg == CW'(i)) begin
                    row_buf[i] <= in_data;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        t_next     = t_reg;
        wr_en_next = '0;
        in_ready   = 1'b0;
        busy       = (state_reg != IDLE);
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                    col_next   = '0;
                    row_next   = '0;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (col_reg == LAST) begin
                        col_next   = '0;
                        row_next   = row_reg + 1'b1;
                        wr_en_next = DEPTH'(1) << row_reg;
                        if (row_reg == LAST) begin
                            state_next = DRAIN;
                            t_next     = '0;
                        end
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                t_next = t_reg + 1'b1;
                if (t_reg == T_END) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    skew_shift_gen #(
        .DEPTH (DEPTH)
    ) u_skew (
        .t        (t_reg),
        .active   (state_reg == DRAIN),
        .shift_en (shift_en)
    );

    assign wr_en = wr_en_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_out
        assign row_out[gi] = row_buf[gi];
    end

endmodule

// File: tb/tb_fifo_row_loader.sv
// Directed bench for fifo_row_loader: reset, continuous and throttled loads,
// skewed drain, protocol misuse and mid-load reset abort.
module tb_fifo_row_loader;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   in_valid = 1'b0;
    logic signed [BITS-1:0] in_data = '0;
    logic                   in_ready;
    logic signed [BITS-1:0] row_out [0:DEPTH-1];
    logic [DEPTH-1:0]       wr_en;
    logic [DEPTH-1:0]       shift_en;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;
    logic signed [BITS-1:0] fifo_model [0:DEPTH-1][0:DEPTH-1];
    int shift_cnt [0:DEPTH-1];

    fifo_row_loader #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .row_out  (row_out),
        .wr_en    (wr_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_shift_en"}, 64'(shift_en), 64'd0);
        for (int c = 0; c < DEPTH; c++) begin
            check({tag, "_row_out"}, row_out[c], 64'd0);
        end
    endtask

    // Model FIFO capture: whatever row_out holds during the strobe cycle.
    task automatic capture_row(input int r);
        for (int c = 0; c < DEPTH; c++) begin
            fifo_model[r][c] = row_out[c];
            check("row_out", row_out[c], 64'(r*DEPTH + c));
        end
        $display("row %0d written to fifo", r);
    endtask

    task automatic run_load(input bit bp, input bit poke);
        int beat;
        int cyc;
        int pend;
        logic [DEPTH-1:0] exp_se;
        beat = 0;
        cyc  = 0;
        pend = -1;
        for (int k = 0; k < DEPTH; k++) begin
            shift_cnt[k] = 0;
            for (int c = 0; c < DEPTH; c++) fifo_model[k][c] = -1;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_fill", 64'(busy), 64'd1);
        while (beat < DEPTH*DEPTH && cyc < 1000) begin
            check("wr_en_fill", 64'(wr_en), (pend >= 0) ? (64'd1 << pend) : 64'd0);
            if (pend >= 0) capture_row(pend);
            check("in_ready_fill", 64'(in_ready), 64'd1);
            check("shift_en_fill", 64'(shift_en), 64'd0);
            pend = -1;
            in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? 64'(beat) : 64'hDEAD_BEEF;
            start    = poke && ($urandom_range(0, 3) == 0);
            tick();
            if (in_valid) begin
                if (beat % DEPTH == DEPTH-1) pend = beat / DEPTH;
                beat++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("beats_accepted", 64'(beat), 64'(DEPTH*DEPTH));
        for (int t = 0; t < 2*DEPTH-1; t++) begin
            check("wr_en_drain", 64'(wr_en), (t == 0) ? (64'd1 << (DEPTH-1)) : 64'd0);
            if (t == 0) capture_row(DEPTH-1);
            exp_se = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (k <= t && t <= k + DEPTH - 1) exp_se[k] = 1'b1;
            end
            check("shift_en_drain", 64'(shift_en), 64'(exp_se));
            check("in_ready_drain", 64'(in_ready), 64'd0);
            check("busy_drain", 64'(busy), 64'd1);
            check("done_drain", 64'(done), 64'd0);
            for (int k = 0; k < DEPTH; k++) shift_cnt[k] += int'(shift_en[k]);
            start    = poke && (t % 3 == 1);
            in_valid = poke;
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("done_pulse", 64'(done), 64'd1);
        check("shift_en_done", 64'(shift_en), 64'd0);
        check("busy_done", 64'(busy), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_after", 64'(done), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("in_ready_idle", 64'(in_ready), 64'd0);
        tick();
        check("start_in_done_ignored", 64'(busy), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            check("shift_count", 64'(shift_cnt[k]), 64'(DEPTH));
            for (int c = 0; c < DEPTH; c++) begin
                check("fifo_model", fifo_model[k][c], 64'(k*DEPTH + c));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle_zero("por");
        rst_n = 1'b1;
        tick();

        // in_valid in IDLE must not be consumed
        in_valid = 1'b1;
        in_data  = 64'sd999;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_in_ready", 64'(in_ready), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;

        $display("continuous load");
        run_load(1'b0, 1'b0);
        $display("backpressure load with start/valid pokes");
        run_load(1'b1, 1'b1);

        $display("reset abort after 20 beats");
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 20; b++) begin
            in_data = 64'(b);
            tick();
        end
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle_zero("rst_mid");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_wr_en", 64'(wr_en), 64'd0);
            check("post_rst_shift_en", 64'(shift_en), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;
        run_load(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
